pwm_seg_decoder: RTL and testbench

- Receive-side checker/monitor for a PWM-dimmed 7-segment bus, i.e. the output side of the team's BCD-to-7-segment converter with PWM brightness control.
- Samples the 8-bit segment bus, measures the on-time over one PWM period, and recovers:
  - the 3-bit brightness level;
  - the lit segment pattern;
  - the BCD digit it encodes.
- Used on-board for loopback self-test and by benches as a scoreboard front end.

---
 rtl/pwm_seg_pkg.sv | 16 +
 rtl/seg7_to_bcd.sv | 40 ++++
 rtl/pwm_seg_decoder.sv | 104 ++++++++++
 tb/tb_pwm_seg_decoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_seg_pkg.sv
// Shared constants and helpers for the PWM 7-segment receive checker.
// Segment order is gfedcba, bit 0 = segment a.
package pwm_seg_pkg;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic [3:0] BCD_INVALID = 4'hF;

    // Level k is reached once on-time crosses the midpoint between duty (k-1)/7 and k/7.
    function automatic logic [63:0] thresh(input int unsigned k, input int unsigned period);
        return ((64'(k) * 64'd2 - 64'd1) * 64'(period)) / 64'd14;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Registered segment-pattern to BCD lookup; updates only when en_i is high.
module seg7_to_bcd
    import pwm_seg_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [6:0] pattern_i,
    output logic [3:0] bcd_o,
    output logic       valid_o
);

    logic [3:0] bcd_d, bcd_q;
    logic       valid_d, valid_q;

    always_comb begin
        bcd_d   = BCD_INVALID;
        valid_d = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (pattern_i == SEG_DIGIT[i]) begin
                bcd_d   = 4'(i);
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bcd_q   <= BCD_INVALID;
            valid_q <= 1'b0;
        end else if (en_i) begin
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
        end
    end

    assign bcd_o   = bcd_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pwm_seg_decoder.sv
// Receive-side monitor for a PWM-dimmed 7-segment bus: measures on-time and lit
// segments over a free-running window of one PWM period and recovers level and digit.
module pwm_seg_decoder
    import pwm_seg_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 125_000_000,
    parameter int unsigned PWM_FREQ    = 1000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seg_pwm_in,
    output logic [2:0] level_out,
    output logic [6:0] pattern_out,
    output logic [3:0] bcd_out,
    output logic       bcd_valid,
    output logic       sample_valid,
    output logic       level_changed
);

    localparam int unsigned PERIOD = CLK_FREQ / PWM_FREQ;
    localparam int unsigned CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned OW     = $clog2(PERIOD + 1);

    logic [7:0]    sync_q [SYNC_STAGES];
    logic [7:0]    s;
    logic          on;
    logic          win_end;
    logic [CW-1:0] cnt_q;
    logic [OW-1:0] on_cnt_q, on_final;
    logic [6:0]    acc_q, acc_final;
    logic [2:0]    level_d, level_q;
    logic [6:0]    pattern_q;
    logic          sample_valid_q, level_changed_q;
    logic          unused_dp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= seg_pwm_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s         = sync_q[SYNC_STAGES-1];
    assign unused_dp = s[7];
    assign on        = |s[6:0];
    assign win_end   = (cnt_q == CW'(PERIOD - 1));

    // Final-cycle sample is folded in before the window results are latched.
    assign on_final  = on_cnt_q + OW'(on);
    assign acc_final = acc_q | s[6:0];

    always_comb begin
        level_d = 3'd0;
        for (int unsigned k = 1; k <= 7; k++) begin
            if (64'(on_final) >= thresh(k, PERIOD)) level_d = level_d + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q           <= '0;
            on_cnt_q        <= '0;
            acc_q           <= '0;
            level_q         <= '0;
            pattern_q       <= '0;
            sample_valid_q  <= 1'b0;
            level_changed_q <= 1'b0;
        end else begin
            sample_valid_q <= win_end;
            if (win_end) begin
                cnt_q           <= '0;
                on_cnt_q        <= '0;
                acc_q           <= '0;
                level_q         <= level_d;
                pattern_q       <= acc_final;
                level_changed_q <= (level_d != level_q);
            end else begin
                cnt_q           <= cnt_q + CW'(1);
                on_cnt_q        <= on_final;
                acc_q           <= acc_final;
                level_changed_q <= 1'b0;
            end
        end
    end

    // Lookup is fed the final accumulator value so it lands together with the other outputs.
    seg7_to_bcd u_seg7_to_bcd (
        .clk_i     (clk),
        .rst_ni    (reset),
        .en_i      (win_end),
        .pattern_i (acc_final),
        .bcd_o     (bcd_out),
        .valid_o   (bcd_valid)
    );

    assign level_out     = level_q;
    assign pattern_out   = pattern_q;
    assign sample_valid  = sample_valid_q;
    assign level_changed = level_changed_q;

endmodule

// File: tb/tb_pwm_seg_decoder.sv
// Scoreboard bench for pwm_seg_decoder: a window-level stream model queues expected
// results as stimulus is driven; a monitor compares on every sample_valid pulse.
module tb_pwm_seg_decoder;

    localparam int unsigned PERIOD = 14;
    localparam int unsigned SYNC   = 2;

    typedef struct {
        logic [2:0] level;
        logic [6:0] pattern;
        logic [3:0] bcd;
        logic       valid;
        logic       changed;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] seg_pwm_in = 8'h00;
    logic [2:0] level_out;
    logic [6:0] pattern_out;
    logic [3:0] bcd_out;
    logic       bcd_valid;
    logic       sample_valid;
    logic       level_changed;

    int n_checks = 0;
    int n_errors = 0;

    exp_t        exp_q[$];
    logic [7:0]  dq[$];
    int unsigned win_on;
    logic [6:0]  win_acc;
    int unsigned win_pos;
    logic [2:0]  prev_level;
    int unsigned edges;
    bit          first_pending = 1'b0;

    pwm_seg_decoder #(
        .CLK_FREQ    (1400),
        .PWM_FREQ    (100),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .seg_pwm_in    (seg_pwm_in),
        .level_out     (level_out),
        .pattern_out   (pattern_out),
        .bcd_out       (bcd_out),
        .bcd_valid     (bcd_valid),
        .sample_valid  (sample_valid),
        .level_changed (level_changed)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void digit_of(input logic [6:0] p, output logic [3:0] d, output logic v);
        v = 1'b1;
        case (p)
            7'h3F: d = 4'd0;
            7'h06: d = 4'd1;
            7'h5B: d = 4'd2;
            7'h4F: d = 4'd3;
            7'h66: d = 4'd4;
            7'h6D: d = 4'd5;
            7'h7D: d = 4'd6;
            7'h07: d = 4'd7;
            7'h7F: d = 4'd8;
            7'h6F: d = 4'd9;
            default: begin d = 4'hF; v = 1'b0; end
        endcase
    endfunction

    function automatic void model_reset();
        dq.delete();
        for (int i = 0; i < SYNC; i++) dq.push_back(8'h00);
        win_on     = 0;
        win_acc    = '0;
        win_pos    = 0;
        prev_level = '0;
    endfunction

    // Drive one cycle; the model sees the bus SYNC cycles later, in whole windows.
    task automatic drive(input logic [7:0] val);
        logic [7:0]  smp;
        exp_t        e;
        int unsigned lvl;
        seg_pwm_in = val;
        dq.push_back(val);
        smp = dq.pop_front();
        if (smp[6:0] != 7'h00) win_on++;
        win_acc |= smp[6:0];
        win_pos++;
        if (win_pos == PERIOD) begin
            // Nearest level with ties rounding up: duty = level/7.
            lvl = (2 * win_on * 7 + PERIOD) / (2 * PERIOD);
            if (lvl > 7) lvl = 7;
            e.level   = 3'(lvl);
            e.pattern = win_acc;
            digit_of(win_acc, e.bcd, e.valid);
            e.changed = (e.level != prev_level);
            prev_level = e.level;
            exp_q.push_back(e);
            win_on  = 0;
            win_acc = '0;
            win_pos = 0;
        end
        @(negedge clk);
    endtask

    task automatic pwm(input logic [7:0] pat, input int on_len, input int periods, input int phase);
        for (int t = 0; t < periods * PERIOD; t++)
            drive((((t + phase) % PERIOD) < on_len) ? pat : 8'h00);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_level"},   32'(level_out),     32'h0);
        check({tag, "_pattern"}, 32'(pattern_out),   32'h0);
        check({tag, "_bcd"},     32'(bcd_out),       32'hF);
        check({tag, "_valid"},   32'(bcd_valid),     32'h0);
        check({tag, "_pulse"},   32'(sample_valid),  32'h0);
        check({tag, "_changed"}, 32'(level_changed), 32'h0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        model_reset();
        first_pending = 1'b1;
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset && sample_valid) begin
            if (first_pending) begin
                check("first_pulse_cycle", 32'(edges + 1), 32'd15);
                first_pending = 1'b0;
            end
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("level",   32'(level_out),     32'(e.level));
                check("pattern", 32'(pattern_out),   32'(e.pattern));
                check("bcd",     32'(bcd_out),       32'(e.bcd));
                check("valid",   32'(bcd_valid),     32'(e.valid));
                check("changed", 32'(level_changed), 32'(e.changed));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pat;
        logic [6:0] digits [10];
        digits = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

        // Held in reset with arbitrary input
        repeat (5) begin
            @(negedge clk);
            seg_pwm_in = 8'($urandom);
        end
        check_cleared("in_reset");
        release_reset();

        pwm(8'h5B, 8, 4, 0);
        pwm(8'h7F, 14, 3, 0);
        pwm(8'h00, 0, 3, 0);
        pwm({1'b0, digits[$urandom_range(0, 9)]}, 2, 3, $urandom_range(0, 13));
        pwm({1'b0, digits[$urandom_range(0, 9)]}, 3, 3, $urandom_range(0, 13));
        pwm(8'h80, 14, 3, 0);

        repeat (20) drive(8'h06);
        repeat (20) drive(8'h4F);
        repeat (20) drive(8'h06);
        repeat (20) drive(8'h5B);

        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 1) == 1) pat = 8'($urandom);
            else pat = {1'($urandom), digits[$urandom_range(0, 9)]};
            pwm(pat, $urandom_range(0, 14), $urandom_range(2, 3), $urandom_range(0, 13));
        end

        // Reset mid-window: partial window discarded, outputs clear at once
        pwm(8'h6D, 10, 2, 0);
        while (win_pos != 7) drive(8'h6D);
        #2 reset = 1'b0;
        #1 check_cleared("async_reset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        release_reset();
        pwm(8'h7D, 14, 3, 0);
        pwm(8'h66, 6, 2, 5);

        repeat (2 * PERIOD) drive(8'h00);
        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("first_pulse_seen", 32'(first_pending), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
